// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one access at a time over a word-wide valid/ready port,
// with byte-lane steering for stores, sign/zero extension for loads, and misalignment traps.
module rv32i_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic              resp_wb,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    function automatic logic access_legal(input logic store, input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (funct3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (off[0] == 1'b0);
            3'd2:    ok = (off == 2'b00);
            3'd4:    ok = !store;
            3'd5:    ok = !store && (off[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] strb;
        strb = 4'b0000;
        case (funct3)
            3'd0:    strb = 4'b0001 << off;
            3'd1:    strb = 4'b0011 << off;
            3'd2:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replicating the datum across lanes lets the strobe alone pick the target bytes.
    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] data;
        data = wdata;
        case (funct3)
            3'd0:    data = {4{wdata[7:0]}};
            3'd1:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] funct3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [31:0] data;
        shifted = rdata >> {off, 3'b000};
        data    = shifted;
        case (funct3)
            3'd0:    data = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    data = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    data = {24'd0, shifted[7:0]};
            3'd5:    data = {16'd0, shifted[15:0]};
            default: data = shifted;
        endcase
        return data;
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_wb_q, resp_wb_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_wb_d    = 1'b0;
        resp_rd_d    = resp_rd_q;
        resp_data_d  = resp_data_q;
        err_valid_d  = 1'b0;
        err_addr_d   = err_addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d    = req_addr[1:0];
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    rd_d     = req_rd;
                    if (access_legal(req_store, req_funct3, req_addr[1:0])) begin
                        state_d     = S_REQ;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_we_d    = req_store;
                        mem_wstrb_d = req_store ? store_strb(req_funct3, req_addr[1:0]) : 4'b0000;
                        mem_wdata_d = req_store ? store_data(req_funct3, req_wdata) : 32'd0;
                    end else begin
                        state_d     = S_ERR;
                        err_valid_d = 1'b1;
                        err_addr_d  = req_addr;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (store_q) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_wb_d    = 1'b0;
                        resp_rd_d    = rd_q;
                        resp_data_d  = 32'd0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_wb_d    = (rd_q != 5'd0);
                    resp_rd_d    = rd_q;
                    resp_data_d  = load_extract(funct3_q, off_q, mem_rdata);
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            off_q        <= 2'd0;
            store_q      <= 1'b0;
            funct3_q     <= 3'd0;
            rd_q         <= 5'd0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wstrb_q  <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_wb_q    <= 1'b0;
            resp_rd_q    <= 5'd0;
            resp_data_q  <= 32'd0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_wb_q    <= resp_wb_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_wb    = resp_wb_q;
    assign resp_rd    = resp_rd_q;
    assign resp_data  = resp_data_q;
    assign err_valid  = err_valid_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Randomized self-checking bench for rv32i_lsu against a behavioural memory-access model.
module tb_rv32i_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_wb;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        err_valid;
    logic [31:0] err_addr;

    int errors = 0;
    int checks = 0;

    rv32i_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_store(req_store), .req_funct3(req_funct3), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_wb(resp_wb), .resp_rd(resp_rd), .resp_data(resp_data),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Access size in bytes is 1, 2 or 4 from funct3[1:0]; anything outside the RV32I table traps.
    function automatic bit ref_legal(input bit st, input int f3, input int unsigned addr);
        int unsigned size;
        if (st && f3 > 2) return 1'b0;
        if (!st && (f3 == 3 || f3 > 5)) return 1'b0;
        size = 1 << (f3 % 4);
        return (addr % size) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int unsigned off, input logic [31:0] rdata);
        logic [31:0] word;
        int v;
        word = rdata >> (8 * off);
        case (f3)
            0: begin v = int'(word & 32'hFF);   if (v > 127)   v = v - 256;   return 32'(v); end
            1: begin v = int'(word & 32'hFFFF); if (v > 32767) v = v - 65536; return 32'(v); end
            4: return word & 32'hFF;
            5: return word & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_strb(input bit st, input int f3, input int unsigned off);
        if (!st) return 32'd0;
        case (f3)
            0: return 32'd1 << off;
            1: return 32'd3 << off;
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] wd);
        case (f3)
            0: return (wd & 32'hFF) * 32'h01010101;
            1: return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle again.
    task automatic run_access(input bit st, input int f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] rdata, input int rdy_dly, input int rv_dly);
        bit legal;
        logic [31:0] eaddr;
        legal = ref_legal(st, f3, addr);
        eaddr = addr & 32'hFFFFFFFC;
        chk("req_ready_idle", req_ready, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = 3'(f3);
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
        req_funct3 = 3'($urandom);
        req_store  = 1'($urandom);
        mem_rvalid = 1'b0;
        if (!legal) begin
            chk("err_valid", err_valid, 32'd1);
            chk("err_addr", err_addr, addr);
            chk("err_mem_valid", mem_valid, 32'd0);
            chk("err_resp_valid", resp_valid, 32'd0);
            chk("err_req_ready", req_ready, 32'd0);
            @(negedge clk);
            chk("err_pulse_end", err_valid, 32'd0);
            chk("err_mem_valid2", mem_valid, 32'd0);
            chk("err_req_ready2", req_ready, 32'd1);
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("mem_valid", mem_valid, 32'd1);
            chk("mem_addr", mem_addr, eaddr);
            chk("mem_we", mem_we, 32'(st));
            chk("mem_wstrb", mem_wstrb, ref_strb(st, f3, addr % 4));
            if (st) chk("mem_wdata", mem_wdata, ref_wdata(f3, wd));
            chk("req_ready_busy", req_ready, 32'd0);
            chk("resp_early", resp_valid, 32'd0);
            mem_ready  = (i == rdy_dly);
            mem_rvalid = !mem_ready && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            @(negedge clk);
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        chk("mem_valid_drop", mem_valid, 32'd0);
        if (!st) begin
            for (int i = 0; i <= rv_dly; i++) begin
                chk("resp_wait", resp_valid, 32'd0);
                chk("req_ready_wait", req_ready, 32'd0);
                mem_rvalid = (i == rv_dly);
                mem_rdata  = (i == rv_dly) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            chk("ld_resp_valid", resp_valid, 32'd1);
            chk("ld_resp_data", resp_data, ref_load(f3, addr % 4, rdata));
            chk("ld_resp_rd", resp_rd, 32'(rd));
            chk("ld_resp_wb", resp_wb, (rd != 5'd0) ? 32'd1 : 32'd0);
        end else begin
            chk("st_resp_valid", resp_valid, 32'd1);
            chk("st_resp_wb", resp_wb, 32'd0);
            chk("st_resp_data", resp_data, 32'd0);
        end
        chk("resp_req_ready", req_ready, 32'd0);
        @(negedge clk);
        chk("resp_pulse_end", resp_valid, 32'd0);
        chk("req_ready_back", req_ready, 32'd1);
    endtask

    // Start an LW, hit reset in REQ or WAIT, then deliver a late read return that must be dropped.
    task automatic reset_midflight(input bit in_wait);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h00005000;
        req_rd     = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_pre_mem_valid", mem_valid, 32'd1);
        if (in_wait) begin
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mem_valid", mem_valid, 32'd0);
        chk("rst_req_ready", req_ready, 32'd1);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst_stray_resp", resp_valid, 32'd0);
        chk("rst_stray_ready", req_ready, 32'd1);
        @(negedge clk);
        chk("rst_stray_resp2", resp_valid, 32'd0);
        chk("rst_mem_valid2", mem_valid, 32'd0);
        run_access(1'b0, 2, 32'h00005004, 32'd0, 5'd9, 32'hCAFEF00D, 0, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        chk("rst_req_ready", req_ready, 32'd1);
        chk("rst_mem_valid", mem_valid, 32'd0);
        chk("rst_mem_we", mem_we, 32'd0);
        chk("rst_mem_wstrb", mem_wstrb, 32'd0);
        chk("rst_resp_valid", resp_valid, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_err_valid", err_valid, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray_rvalid_resp", resp_valid, 32'd0);

        run_access(1'b0, 0, 32'h00001003, 32'd0, 5'd5, 32'h80123456, 0, 0);
        run_access(1'b0, 5, 32'h00002002, 32'd0, 5'd6, 32'hBEEF1234, 0, 0);
        run_access(1'b0, 1, 32'h00002002, 32'd0, 5'd6, 32'hBEEF1234, 1, 1);
        run_access(1'b1, 0, 32'h00003001, 32'h000000AB, 5'd3, 32'd0, 0, 0);
        run_access(1'b0, 2, 32'h00004002, 32'd0, 5'd1, 32'd0, 0, 0);
        run_access(1'b1, 1, 32'h00004001, 32'h1234, 5'd1, 32'd0, 0, 0);
        run_access(1'b0, 2, 32'h00004000, 32'd0, 5'd0, 32'h55AA55AA, 3, 2);
        run_access(1'b1, 2, 32'h00004008, 32'hA5A5F00F, 5'd2, 32'd0, 2, 0);
        reset_midflight(1'b1);
        reset_midflight(1'b0);

        for (int n = 0; n < 200; n++) begin
            run_access(1'($urandom), int'($urandom_range(0, 7)), $urandom, $urandom,
                       5'($urandom), $urandom, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit in the RV32I execute path, directly downstream of `rv32i_alu`. It consumes the ALU ADD result as the effective address and performs one load or store at a time over a word-wide valid/ready memory port, handling byte-lane steering and sign/zero extension. Misaligned or illegal accesses are rejected without touching memory. Load data is returned to writeback as a one-cycle response.

## Interface
- `ADDR_W`, 32: address width; `mem_addr` and `err_addr` use this width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute stage presents an access.
- `req_ready` out 1: LSU can accept; high only in IDLE.
- `req_addr` in ADDR_W: effective address (ALU ADD result).
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3. Loads: LB 0, LH 1, LW 2, LBU 4, LHU 5. Stores: SB 0, SH 1, SW 2.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register.
- `mem_valid` out 1, `mem_ready` in 1: memory request handshake.
- `mem_addr` out ADDR_W: word-aligned address, `{req_addr[ADDR_W-1:2],2'b00}`.
- `mem_we` out 1, `mem_wstrb` out 4, `mem_wdata` out 32: write controls and data.
- `mem_rvalid` in 1, `mem_rdata` in 32: load data return.
- `resp_valid` out 1: one-cycle completion pulse for every accepted legal access.
- `resp_wb` out 1: write back to the register file. Equals load && rd≠0.
- `resp_rd` out 5, `resp_data` out 32: writeback target and data. `resp_data` is 0 for stores.
- `err_valid` out 1, `err_addr` out ADDR_W: one-cycle pulse reporting a misaligned or illegal access, with its address.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - REQ: `mem_valid`=1.
  - WAIT: load data pending.
  - RESP: `resp_valid`=1.
  - ERR: `err_valid`=1.
- IDLE, `req_valid`=1: latch addr, store, funct3, wdata, rd.
  - Legal access: go to REQ.
  - Otherwise: go to ERR.
- Illegal access:
  - load funct3 3, 6 or 7;
  - store funct3 of 3 or above;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- ERR: pulse `err_valid` with `err_addr`=latched address. No memory request, no `resp_valid`. Go to IDLE.
- REQ: hold all `mem_*` outputs stable until `mem_ready`=1.
  - Store: go to RESP.
  - Load: go to WAIT.
- Store steering, where o = addr[1:0]:
  - SB: `mem_wdata` = {4{wdata[7:0]}}, `mem_wstrb` = 4'b0001<<o.
  - SH: `mem_wdata` = {2{wdata[15:0]}}, `mem_wstrb` = 4'b0011<<o.
  - SW: `mem_wdata` = wdata, `mem_wstrb` = 4'b1111.
  - `mem_we`=1.
- Loads: `mem_we`=0, `mem_wstrb`=0.
- WAIT: on `mem_rvalid`, shift `mem_rdata` right by 8·addr[1:0] and register the extracted value.
  - LB and LH sign-extend from bit 7 and bit 15.
  - LBU and LHU zero-extend.
  - LW passes the word through.
  - Then go to RESP.
- `mem_rvalid` is ignored outside WAIT, including a stray return after reset.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- No request pipelining: one outstanding access maximum.

## Timing
- Reset: state=IDLE; all outputs 0 except `req_ready`=1.
- `rst` overrides everything, including mid-REQ and mid-WAIT. In-flight requests are abandoned and `mem_valid` drops at the first edge with `rst` high.
- Request accepted at edge T:
  - `mem_valid` high at T+1.
  - Store with `mem_ready` at T+1: `resp_valid` at T+2, `req_ready` at T+3.
  - Load with `mem_ready` at T+1 and `mem_rvalid` at T+2: `resp_valid` at T+3, `req_ready` at T+4.
  - `mem_rvalid` is sampled no earlier than the cycle after the memory handshake.
  - Error: `err_valid` at T+1, `req_ready` at T+2.
- Each cycle of `mem_ready` low adds one cycle; each cycle of `mem_rvalid` low in WAIT adds one cycle.
- `resp_*` and `err_*` are registered, never combinational from inputs.
- `req_ready` is a decode of state only.

## Test plan
- LB at 0x1003, `mem_rdata`=0x80123456 → `mem_addr`=0x1000, `resp_data`=0xFFFFFF80, `resp_rd`=latched rd, `resp_wb`=1.
- LHU at 0x2002, `mem_rdata`=0xBEEF1234 → `resp_data`=0x0000BEEF. The same access as LH → 0xFFFFBEEF.
- SB at 0x3001, wdata=0x000000AB → `mem_wstrb`=0010, `mem_wdata`=0xABABABAB, `mem_we`=1, `resp_valid` with `resp_wb`=0.
- LW at 0x4002 and SH at 0x4001 → `err_valid` pulse with `err_addr`=0x4002, then 0x4001. `mem_valid` never asserts.
- LW with `mem_ready` low for 3 cycles and `mem_rvalid` delayed 2 cycles → `mem_*` outputs stable throughout, `resp_valid` exactly once, `req_ready` low until completion.
- `rst` asserted in WAIT, `mem_rvalid` arrives after reset → no `resp_valid`, `req_ready`=1, next LW completes normally.
